// File: rtl/vmem_pkg.sv
// Shared video-memory types: pixel, packed {h, v} address and the address builder.
// Used by the arbiter, the framebuffer wrapper and the VGA glue.
package vmem_pkg;
    localparam int HW     = 10;
    localparam int VW     = 9;
    localparam int DW     = 24;
    localparam int RD_LAT = 2;

    typedef logic [DW-1:0]    pix_t;
    typedef logic [HW+VW-1:0] vaddr_t;

    typedef struct packed {
        vaddr_t addr;
        pix_t   data;
    } wentry_t;

    function automatic vaddr_t mk_addr(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return {h, v};
    endfunction
endpackage

// File: rtl/vmem_wfifo.sv
// Write-buffer FIFO for the video memory arbiter. Head is visible combinationally;
// an entry pushed this cycle becomes the head no earlier than the next cycle.
module vmem_wfifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic [W-1:0]            din,
    input  logic                    pop,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    assign dout  = mem[rptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Storage needs no reset: pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

// File: rtl/vmem_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, writer pixels are
// buffered and retired on cycles the display leaves the RAM free.
module vmem_arbiter #(
    parameter int HW    = vmem_pkg::HW,
    parameter int VW    = vmem_pkg::VW,
    parameter int DW    = vmem_pkg::DW,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   disp_valid,
    input  logic [HW-1:0]          disp_h_addr,
    input  logic [VW-1:0]          disp_v_addr,
    output logic [DW-1:0]          disp_data,
    output logic                   disp_rvalid,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [HW-1:0]          wr_h_addr,
    input  logic [VW-1:0]          wr_v_addr,
    input  logic [DW-1:0]          wr_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [HW+VW-1:0]       mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   wr_idle,
    output logic [15:0]            stall_cnt
);
    localparam int AW = HW + VW;
    localparam int EW = AW + DW;
    localparam int RL = vmem_pkg::RD_LAT;

    logic [EW-1:0] head;
    logic          full, empty, push, rd_gnt, wr_gnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [RL:1]   vld_pipe;

    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;

    // Strobes are gated by resetn so the RAM sees nothing while reset is held.
    assign rd_gnt = resetn & disp_valid;
    assign wr_gnt = resetn & ~disp_valid & ~empty;

    assign mem_en      = rd_gnt | wr_gnt;
    assign mem_we      = wr_gnt;
    assign mem_addr    = rd_gnt ? {disp_h_addr, disp_v_addr}
                       : wr_gnt ? head[EW-1:DW] : addr_q;
    assign mem_wdata   = wr_gnt ? head[DW-1:0] : wdata_q;
    assign wr_idle     = empty & ~wr_gnt;
    assign disp_rvalid = vld_pipe[RL];

    vmem_wfifo #(.W(EW), .DEPTH(DEPTH)) u_wfifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .din   ({wr_h_addr, wr_v_addr, wr_data}),
        .pop   (wr_gnt),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            vld_pipe  <= '0;
            disp_data <= '0;
            stall_cnt <= '0;
        end else begin
            if (mem_en) addr_q  <= mem_addr;
            if (wr_gnt) wdata_q <= mem_wdata;
            vld_pipe <= {vld_pipe[RL-1:1], rd_gnt};
            // RAM data for a read issued last cycle is present now.
            if (vld_pipe[RL-1]) disp_data <= mem_rdata;
            if (wr_valid && full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
